// File: rtl/parity_serial_tx.sv
// Serial parity transmitter: shifts a parallel word out MSB-first and appends one parity bit.
// state | meaning: IDLE ready for a word; SHIFT data bits on ser_out; PARITY parity bit on ser_out.
module parity_serial_tx #(
    parameter int WIDTH = 3,
    parameter bit ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             par_bit,
    output logic             parity_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             pout_q, pout_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        pout_d  = pout_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_SHIFT;
                    shift_d = data_in;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            S_SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                par_d   = par_q ^ shift_q[WIDTH-1];
                if (cnt_q == LAST) begin
                    state_d = S_PARITY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                pout_d = par_q ^ ODD;
                // A load here starts the next frame without an idle cycle.
                if (load) begin
                    state_d = S_SHIFT;
                    shift_d = data_in;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            pout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            pout_q  <= pout_d;
        end
    end

    always_comb begin
        ser_out = 1'b0;
        case (state_q)
            S_SHIFT:  ser_out = shift_q[WIDTH-1];
            S_PARITY: ser_out = par_q ^ ODD;
            default:  ser_out = 1'b0;
        endcase
    end

    assign ready      = (state_q != S_SHIFT);
    assign ser_valid  = (state_q == S_SHIFT) || (state_q == S_PARITY);
    assign par_bit    = (state_q == S_PARITY);
    assign parity_out = pout_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Bench for parity_serial_tx: even and odd instances share stimulus and are checked against
// a queue-based frame model built from the frame rules.
module tb_parity_serial_tx;

    logic       clk;
    logic       reset;
    logic       load;
    logic [2:0] data_in;

    logic ready_e, ser_out_e, ser_valid_e, par_bit_e, parity_out_e;
    logic ready_o, ser_out_o, ser_valid_o, par_bit_o, parity_out_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Each entry is one expected frame bit: [2] parity flag, [1] bit for even, [0] bit for odd.
    logic [2:0] exp_q[$];
    logic       lp_e, lp_o;

    parity_serial_tx #(.WIDTH(3), .ODD(1'b0)) u_even (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in),
        .ready(ready_e), .ser_out(ser_out_e), .ser_valid(ser_valid_e),
        .par_bit(par_bit_e), .parity_out(parity_out_e)
    );

    parity_serial_tx #(.WIDTH(3), .ODD(1'b1)) u_odd (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in),
        .ready(ready_o), .ser_out(ser_out_o), .ser_valid(ser_valid_o),
        .par_bit(par_bit_o), .parity_out(parity_out_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        lp_e = 1'b0;
        lp_o = 1'b0;
    endtask

    task automatic push_frame(input logic [2:0] d);
        logic even_par;
        even_par = ($countones(d) % 2) == 1;
        for (int i = 2; i >= 0; i--) exp_q.push_back({1'b0, d[i], d[i]});
        exp_q.push_back({1'b1, even_par, ~even_par});
    endtask

    task automatic model_edge();
        logic       accept;
        logic [2:0] front;
        if (!reset) begin
            model_reset();
            return;
        end
        accept = load && (exp_q.size() == 0 || exp_q[0][2]);
        if (exp_q.size() > 0) begin
            front = exp_q.pop_front();
            if (front[2]) begin
                lp_e = front[1];
                lp_o = front[0];
            end
        end
        if (accept) push_frame(data_in);
    endtask

    task automatic compare();
        logic       nonempty;
        logic [2:0] f;
        nonempty = exp_q.size() > 0;
        f = nonempty ? exp_q[0] : 3'b000;
        chk("even.ready",      ready_e,      !nonempty || f[2]);
        chk("even.ser_valid",  ser_valid_e,  nonempty);
        chk("even.ser_out",    ser_out_e,    nonempty ? f[1] : 1'b0);
        chk("even.par_bit",    par_bit_e,    nonempty && f[2]);
        chk("even.parity_out", parity_out_e, lp_e);
        chk("odd.ready",       ready_o,      !nonempty || f[2]);
        chk("odd.ser_valid",   ser_valid_o,  nonempty);
        chk("odd.ser_out",     ser_out_o,    nonempty ? f[0] : 1'b0);
        chk("odd.par_bit",     par_bit_o,    nonempty && f[2]);
        chk("odd.parity_out",  parity_out_o, lp_o);
    endtask

    task automatic edge_check();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic step(input logic ld, input logic [2:0] d);
        @(negedge clk);
        load    = ld;
        data_in = d;
        edge_check();
    endtask

    task automatic frame(input logic [2:0] d);
        step(1'b1, d);
        repeat (4) step(1'b0, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        load    = 1'b0;
        data_in = 3'b000;
        model_reset();
        #1;
        compare();

        // Loads during reset must not start a frame.
        step(1'b1, 3'b101);
        step(1'b1, 3'b111);

        // First edge after release accepts a load.
        @(negedge clk);
        reset   = 1'b1;
        load    = 1'b1;
        data_in = 3'b101;
        edge_check();
        repeat (4) step(1'b0, 3'b000);

        frame(3'b111);
        frame(3'b000);
        frame(3'b110);

        // Busy loads ignored; back-to-back frame accepted in the parity cycle.
        step(1'b1, 3'b100);
        step(1'b1, 3'b111);
        step(1'b0, 3'b000);
        step(1'b0, 3'b000);
        step(1'b1, 3'b011);
        step(1'b1, 3'b111);
        step(1'b0, 3'b000);
        step(1'b0, 3'b000);
        step(1'b0, 3'b000);

        // Asynchronous reset in the middle of a frame.
        step(1'b1, 3'b110);
        step(1'b0, 3'b000);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare();
        step(1'b0, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        frame(3'b001);

        for (int d = 0; d < 8; d++) frame(3'(d));

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)));
        end
        repeat (5) step(1'b0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
